// File: rtl/fpga_cfg_pkg.sv
// rtl/fpga_cfg_pkg.sv - shared types and helpers for the LUT configuration loader
// Contents:
//   LUT_W       width of one LUT truth table (16 for a 4-input LUT)
//   cfg_state_e loader FSM states
//   end_addr()  all-ones END marker for a given address width
package fpga_cfg_pkg;

  localparam int LUT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } cfg_state_e;

  // Returns a LUT_W-wide word whose low addr_w bits are set.
  function automatic logic [LUT_W-1:0] end_addr(input int unsigned addr_w);
    logic [LUT_W-1:0] r;
    r = '0;
    for (int i = 0; i < LUT_W; i++) begin
      if (i < int'(addr_w)) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fpga_cfg_shreg.sv
// rtl/fpga_cfg_shreg.sv - MSB-first field deserialiser with bit counter
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   shift_en_i     accept bit_i this cycle
//   clear_i        discard any partial field (has priority over shift_en_i)
//   bit_i          serial input bit
//   len_i          field length in bits (1..16)
//   word_o         field value including bit_i (valid when word_done_o)
//   word_done_o    high in the cycle the last bit of the field is accepted
module fpga_cfg_shreg
  import fpga_cfg_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shift_en_i,
  input  logic             clear_i,
  input  logic             bit_i,
  input  logic [4:0]       len_i,
  output logic [LUT_W-1:0] word_o,
  output logic             word_done_o
);

  logic [LUT_W-1:0] sh_q, sh_d;
  logic [4:0]       cnt_q, cnt_d;

  // The completed word is presented combinationally so the owner can latch it
  // on the same edge that accepts the final bit.
  assign word_o      = {sh_q[LUT_W-2:0], bit_i};
  assign word_done_o = shift_en_i && !clear_i && (cnt_q == len_i - 5'd1);

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (shift_en_i) begin
      if (word_done_o) begin
        // Restart empty so short fields (address) read zero in unused bits.
        sh_d  = '0;
        cnt_d = '0;
      end else begin
        sh_d  = word_o;
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// rtl/fpga_cfg_loader.sv - serial (address, truth table) frame loader driving LUT write port
// Optional feature macro: CFG_CHECKSUM_EN (XOR checksum field after END marker).
// Parameters: NUM_LUTS (1..255), ADDR_W (frame address width, all-ones = END).
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   cfg_start_i    begin/restart a session (wins over a coincident bit)
//   cfg_valid_i    cfg_bit_i valid
//   cfg_bit_i      serial config bit, MSB first
//   cfg_ready_o    bit accepted when valid & ready
//   lut_data_o     shared truth-table bus, holds last written word
//   lut_we_o       one-hot write strobe, single-cycle pulse
//   busy_o         session in progress
//   done_o         session ended cleanly (held)
//   err_o          session aborted (held)
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int NUM_LUTS = 16,
  parameter int ADDR_W   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_start_i,
  input  logic                cfg_valid_i,
  input  logic                cfg_bit_i,
  output logic                cfg_ready_o,
  output logic [LUT_W-1:0]    lut_data_o,
  output logic [NUM_LUTS-1:0] lut_we_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  localparam logic [LUT_W-1:0] END_W = end_addr(ADDR_W);

  cfg_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [LUT_W-1:0]    lut_data_q, lut_data_d;
  logic [NUM_LUTS-1:0] lut_we_q, lut_we_d;

  logic                shift_en;
  logic [4:0]          len;
  logic [LUT_W-1:0]    word;
  logic                word_done;
  logic [ADDR_W-1:0]   addr_word;

`ifdef CFG_CHECKSUM_EN
  logic [LUT_W-1:0]    csum_q, csum_d;
`endif

  // A start in the same cycle as a valid bit drops that bit.
  assign shift_en  = cfg_valid_i && ready_q && !cfg_start_i;
  assign len       = (state_q == ADDR) ? 5'(ADDR_W) : 5'(LUT_W);
  assign addr_word = word[ADDR_W-1:0];

  fpga_cfg_shreg u_shreg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .shift_en_i  (shift_en),
    .clear_i     (cfg_start_i),
    .bit_i       (cfg_bit_i),
    .len_i       (len),
    .word_o      (word),
    .word_done_o (word_done)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
`ifdef CFG_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (cfg_start_i) begin
      state_d = ADDR;
`ifdef CFG_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else begin
      case (state_q)
        ADDR: begin
          if (word_done) begin
            addr_d = addr_word;
            if (addr_word == END_W[ADDR_W-1:0]) begin
`ifdef CFG_CHECKSUM_EN
              state_d = CHK;
`else
              state_d = DONE;
`endif
            end else if (int'(addr_word) >= NUM_LUTS) begin
              state_d = ERR;
            end else begin
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (word_done) begin
            state_d = WRITE;
`ifdef CFG_CHECKSUM_EN
            csum_d  = csum_q ^ word;
`endif
          end
        end
        WRITE: state_d = ADDR;
`ifdef CFG_CHECKSUM_EN
        CHK: begin
          if (word_done) state_d = (word == csum_q) ? DONE : ERR;
        end
`endif
        default: ;
      endcase
    end

    // Outputs are registered copies of what the next state implies, so they
    // change on the same edge as the state.
    ready_d    = (state_d == ADDR) || (state_d == DATA) || (state_d == CHK);
    busy_d     = ready_d || (state_d == WRITE);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
    lut_data_d = lut_data_q;
    lut_we_d   = '0;
    // WRITE is only entered from DATA on its last bit, so word is the data.
    if (state_d == WRITE) begin
      lut_data_d = word;
      for (int i = 0; i < NUM_LUTS; i++) begin
        lut_we_d[i] = (int'(addr_q) == i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      lut_data_q <= '0;
      lut_we_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      lut_data_q <= lut_data_d;
      lut_we_q   <= lut_we_d;
    end
  end

`ifdef CFG_CHECKSUM_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) csum_q <= '0;
    else       csum_q <= csum_d;
  end
`endif

  assign cfg_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign lut_data_o  = lut_data_q;
  assign lut_we_o    = lut_we_q;

endmodule
